// File: rtl/msk_g16mul_sched_pkg.sv
// Constants and helpers shared by the masked GF(16) multiplier scheduler.
package msk_g16_sched_pkg;

  localparam int unsigned DEFAULTSHARES = 2;
  localparam int unsigned NBITS         = 4;
  localparam int unsigned FIFO_DEPTH    = 2;
  localparam int unsigned CREDIT_W      = 2;

  // Randomness bits consumed by one HPC3 GF(16) multiplication
  function automatic int unsigned rnd_w(input int unsigned d);
    return NBITS * d * (d - 1);
  endfunction

  // Position of share s of bit k in a bit-slice-major sharing
  function automatic int unsigned sh_idx(input int unsigned d, input int unsigned k,
                                         input int unsigned s);
    return k * d + s;
  endfunction

endpackage

// File: rtl/msk_g16mul_sched_if.sv
// Requester and result handshake bundle of the GF(16) multiplier scheduler.
interface msk_g16mul_sched_if
  import msk_g16_sched_pkg::*;
#(
  parameter int unsigned d    = DEFAULTSHARES,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*NBITS*d-1:0] req_a;
  logic [NREQ*NBITS*d-1:0] req_b;
  logic                    res_valid;
  logic                    res_ready;
  logic [IDW-1:0]          res_id;
  logic [NBITS*d-1:0]      res_data;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data
  );
endinterface

// File: rtl/msk_g16mul_sched_rr.sv
// Round-robin arbiter: picks the first requester at or after ptr and
// produces the pointer value for the next cycle.
module msk_g16mul_sched_rr #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             advance_i,
  output logic [NREQ-1:0]  grant_c_o,
  output logic [PTR_W-1:0] idx_c_o,
  output logic [PTR_W-1:0] ptr_d_c_o
);

  // Wrap-around priority scan and pointer advance past the winner
  always_comb begin
    int unsigned j;
    logic        found;
    grant_c_o = '0;
    idx_c_o   = '0;
    ptr_d_c_o = ptr_i;
    found     = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = 32'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_i[PTR_W'(j)]) begin
        found                  = 1'b1;
        grant_c_o[PTR_W'(j)]   = 1'b1;
        idx_c_o                = PTR_W'(j);
      end
    end
    if (advance_i && found) begin
      ptr_d_c_o = (idx_c_o == PTR_W'(NREQ - 1)) ? '0 : idx_c_o + PTR_W'(1);
    end
  end

endmodule

// File: rtl/msk_g16mul_sched.sv
// Shares one masked HPC3 GF(16) multiplier among NREQ requesters.
// Optional build macro MSKG16_SCHED_IDLE_ZERO_EN: zero operands and
// randomness on idle cycles instead of holding the last issued values.
module msk_g16mul_sched
  import msk_g16_sched_pkg::*;
#(
  parameter int unsigned d    = DEFAULTSHARES,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  msk_g16mul_sched_if.slave      bus,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [rnd_w(d)-1:0]    rnd_in,
  output logic [NBITS*d-1:0]     mul_ina,
  output logic [NBITS*d-1:0]     mul_inb,
  output logic [NBITS*d-1:0]     mul_ina_prev,
  output logic [rnd_w(d)-1:0]    mul_rnd,
  input  logic [NBITS*d-1:0]     mul_out
);

  localparam int unsigned SW    = NBITS * d;
  localparam int unsigned RND_W = rnd_w(d);
  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic                fl_valid_q, fl_valid_d;
  logic [IDW-1:0]      fl_id_q, fl_id_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [IDW-1:0]      fid_q [FIFO_DEPTH];
  logic [SW-1:0]       fdat_q [FIFO_DEPTH];
  logic [SW-1:0]       ina_prev_q;

  logic [NREQ-1:0]     grant;
  logic [PTR_W-1:0]    gidx;
  logic                issue_c, pop_c, push_c;
  logic [SW-1:0]       sel_a, sel_b;

  assign issue_c       = rst_n & (|bus.req_valid) & rnd_valid & (credits_q != '0);
  assign push_c        = fl_valid_q;
  assign pop_c         = bus.res_valid & bus.res_ready;
  assign rnd_ready     = issue_c;
  assign bus.req_ready = issue_c ? grant : '0;
  assign bus.res_valid = rst_n & (cnt_q != 2'd0);
  assign bus.res_id    = fid_q[rd_q];
  assign bus.res_data  = fdat_q[rd_q];
  assign mul_ina_prev  = ina_prev_q;

  msk_g16mul_sched_rr #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .advance_i (issue_c),
    .grant_c_o (grant),
    .idx_c_o   (gidx),
    .ptr_d_c_o (ptr_d)
  );

  // AND-OR operand mux on the one-hot grant; shares stay separate
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (grant[r]) begin
        sel_a = sel_a | bus.req_a[r*SW +: SW];
        sel_b = sel_b | bus.req_b[r*SW +: SW];
      end
    end
  end

`ifdef MSKG16_SCHED_IDLE_ZERO_EN
  // Idle cycles present all-zero operands and randomness
  always_comb begin
    mul_ina = '0;
    mul_inb = '0;
    mul_rnd = '0;
    if (issue_c) begin
      mul_ina = sel_a;
      mul_inb = sel_b;
      mul_rnd = rnd_in;
    end
  end
`else
  logic [SW-1:0]    hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic [RND_W-1:0] hold_r_q, hold_r_d;

  // Idle cycles repeat the last issued values to limit toggling
  always_comb begin
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    hold_r_d = hold_r_q;
    if (issue_c) begin
      hold_a_d = sel_a;
      hold_b_d = sel_b;
      hold_r_d = rnd_in;
    end
    mul_ina = rst_n ? hold_a_d : '0;
    mul_inb = rst_n ? hold_b_d : '0;
    mul_rnd = rst_n ? hold_r_d : '0;
  end

  // Last-issued operand/randomness registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_a_q <= '0;
      hold_b_q <= '0;
      hold_r_q <= '0;
    end else begin
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      hold_r_q <= hold_r_d;
    end
  end
`endif

  // Next state for credits, in-flight stage and result FIFO pointers
  always_comb begin
    credits_d  = credits_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    fl_valid_d = issue_c;
    fl_id_d    = IDW'(gidx);
    case ({issue_c, pop_c})
      2'b10:   credits_d = credits_q - CREDIT_W'(1);
      2'b01:   credits_d = credits_q + CREDIT_W'(1);
      default: ;
    endcase
    case ({push_c, pop_c})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: ;
    endcase
    if (push_c) wr_d = ~wr_q;
    if (pop_c)  rd_d = ~rd_q;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      credits_q  <= CREDIT_W'(FIFO_DEPTH);
      fl_valid_q <= 1'b0;
      fl_id_q    <= '0;
      cnt_q      <= 2'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ina_prev_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      credits_q  <= credits_d;
      fl_valid_q <= fl_valid_d;
      fl_id_q    <= fl_id_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ina_prev_q <= mul_ina;
    end
  end

  // Result FIFO payload; occupancy alone qualifies it, so no reset needed
  always_ff @(posedge clk) begin
    if (push_c) begin
      fid_q[wr_q]  <= fl_id_q;
      fdat_q[wr_q] <= mul_out;
    end
  end

endmodule

// File: tb/tb_msk_g16mul_sched.sv
// Self-checking bench for msk_g16mul_sched with a behavioural masked multiplier.
module tb_msk_g16mul_sched;
  import msk_g16_sched_pkg::*;

  localparam int unsigned D    = 2;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;
  localparam int unsigned W4   = 4 * D;
  localparam int unsigned RW   = 4 * D * (D - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rnd_valid = 1'b0;
  logic          rnd_ready;
  logic [RW-1:0] rnd_in = '0;
  logic [W4-1:0] mul_ina, mul_inb, mul_ina_prev, mul_out;
  logic [RW-1:0] mul_rnd;

  msk_g16mul_sched_if #(.d(D), .NREQ(NREQ), .IDW(IDW)) bus ();

  msk_g16mul_sched #(.d(D), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .rnd_in       (rnd_in),
    .mul_ina      (mul_ina),
    .mul_inb      (mul_inb),
    .mul_ina_prev (mul_ina_prev),
    .mul_rnd      (mul_rnd),
    .mul_out      (mul_out)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] recomb(input logic [W4-1:0] s);
    logic [3:0] v;
    v = 4'h0;
    for (int unsigned k = 0; k < 4; k++)
      for (int unsigned j = 0; j < D; j++)
        v[k] = v[k] ^ s[sh_idx(D, k, j)];
    return v;
  endfunction

  function automatic logic [W4-1:0] mk_share(input logic [3:0] v);
    logic [W4-1:0] s;
    logic          p;
    s = W4'($urandom);
    for (int unsigned k = 0; k < 4; k++) begin
      p = v[k];
      for (int unsigned j = 1; j < D; j++) p = p ^ s[sh_idx(D, k, j)];
      s[sh_idx(D, k, 0)] = p;
    end
    return s;
  endfunction

  function automatic logic [W4-1:0] mask_out(input logic [3:0] p, input logic [RW-1:0] r);
    logic [W4-1:0] s;
    logic          x;
    s = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      x = p[k];
      for (int unsigned j = 1; j < D; j++) begin
        s[sh_idx(D, k, j)] = r[k*(D-1) + j - 1];
        x = x ^ r[k*(D-1) + j - 1];
      end
      s[sh_idx(D, k, 0)] = x;
    end
    return s;
  endfunction

  // Stand-in for the shared multiplier: one-cycle masked product
  always_ff @(posedge clk)
    mul_out <= mask_out(gf_mul(recomb(mul_ina), recomb(mul_inb)), mul_rnd);

  typedef struct {
    int unsigned id;
    logic [3:0]  prod;
    int unsigned avail;
  } exp_t;

  int unsigned   n_chk = 0;
  int unsigned   n_pass = 0;
  int unsigned   cyc = 0;
  bit            pend [NREQ];
  logic [W4-1:0] ra [NREQ];
  logic [W4-1:0] rb [NREQ];
  int unsigned   m_ptr = 0;
  exp_t          q [$];
  logic [W4-1:0] last_a = '0, last_b = '0, prev_ina = '0;
  logic [RW-1:0] last_r = '0, rnd_word = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
  endtask

  // One clock cycle: drive at negedge, predict from the model, compare, update model
  task automatic step(input bit rst, input int unsigned p_req, input logic [NREQ-1:0] mask,
                      input bit rv, input bit rr);
    bit              any, e_issue, e_rv;
    int              g;
    logic [NREQ-1:0] e_rdy;
    logic [W4-1:0]   e_a, e_b;
    logic [RW-1:0]   e_r;
    exp_t            e;
    @(negedge clk);
    rst_n = ~rst;
    for (int r = 0; r < NREQ; r++) begin
      if (!pend[r] && mask[r] && ($urandom_range(99) < p_req)) begin
        pend[r] = 1'b1;
        ra[r]   = mk_share(4'($urandom));
        rb[r]   = mk_share(4'($urandom));
      end
      bus.req_valid[r]        = pend[r];
      bus.req_a[r*W4 +: W4]   = ra[r];
      bus.req_b[r*W4 +: W4]   = rb[r];
    end
    rnd_valid     = rv;
    rnd_in        = rnd_word;
    bus.res_ready = rr;
    #1;
    any = 1'b0;
    for (int r = 0; r < NREQ; r++) any = any | pend[r];
    e_issue = !rst && any && rv && (q.size() < 2);
    g = -1;
    if (e_issue)
      for (int i = 0; i < NREQ; i++)
        if (g < 0 && pend[(int'(m_ptr) + i) % NREQ]) g = (int'(m_ptr) + i) % NREQ;
    e_rdy = '0;
    if (e_issue) e_rdy[g] = 1'b1;
    if (rst) begin
      e_a = '0; e_b = '0; e_r = '0;
    end else if (e_issue) begin
      e_a = ra[g]; e_b = rb[g]; e_r = rnd_word;
    end else begin
`ifdef MSKG16_SCHED_IDLE_ZERO_EN
      e_a = '0; e_b = '0; e_r = '0;
`else
      e_a = last_a; e_b = last_b; e_r = last_r;
`endif
    end
    check_val("req_ready", 32'(bus.req_ready), 32'(e_rdy));
    check_val("rnd_ready", 32'(rnd_ready), 32'(e_issue));
    check_val("mul_ina", 32'(mul_ina), 32'(e_a));
    check_val("mul_inb", 32'(mul_inb), 32'(e_b));
    check_val("mul_rnd", 32'(mul_rnd), 32'(e_r));
    check_val("mul_ina_prev", 32'(mul_ina_prev), 32'(prev_ina));
    e_rv = !rst && (q.size() > 0) && (q[0].avail <= cyc);
    check_val("res_valid", 32'(bus.res_valid), 32'(e_rv));
    if (e_rv) begin
      check_val("res_id", 32'(bus.res_id), q[0].id);
      check_val("res_data", 32'(recomb(bus.res_data)), 32'(q[0].prod));
    end
    prev_ina = e_a;
    if (rst) begin
      q.delete();
      m_ptr  = 0;
      last_a = '0; last_b = '0; last_r = '0;
    end else begin
      if (e_rv && rr) void'(q.pop_front());
      if (e_issue) begin
        e.id    = g;
        e.prod  = gf_mul(recomb(ra[g]), recomb(rb[g]));
        e.avail = cyc + 2;
        q.push_back(e);
        pend[g]  = 1'b0;
        m_ptr    = (g + 1) % NREQ;
        last_a   = ra[g]; last_b = rb[g]; last_r = rnd_word;
        rnd_word = RW'($urandom);
      end
    end
    cyc++;
  endtask

  initial begin
    for (int r = 0; r < NREQ; r++) begin
      pend[r] = 1'b0; ra[r] = '0; rb[r] = '0;
    end
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b0;
    rnd_word = RW'($urandom);

    repeat (2) step(1'b1, 0, '0, 1'b1, 1'b1);

    // Single requester: a=5, b=0 -> product 0, tag 0, valid two cycles later
    pend[0] = 1'b1;
    ra[0]   = mk_share(4'h5);
    rb[0]   = mk_share(4'h0);
    repeat (4) step(1'b0, 0, '0, 1'b1, 1'b1);

    // All requesters continuously valid, consumer always ready
    repeat (20) step(1'b0, 100, 4'hF, 1'b1, 1'b1);

    // Backpressure: two accepts then stall, then drain in order
    repeat (6) step(1'b0, 100, 4'hF, 1'b1, 1'b0);
    repeat (6) step(1'b0, 100, 4'hF, 1'b1, 1'b1);

    // Randomness availability toggling
    for (int i = 0; i < 10; i++) step(1'b0, 100, 4'hF, (i % 2) == 0, 1'b1);

    // Mixed random traffic
    for (int i = 0; i < 300; i++)
      step(1'b0, 50, 4'hF, $urandom_range(99) < 80, $urandom_range(99) < 70);

    // Drain, then reset with one buffered and one in-flight operation
    repeat (10) step(1'b0, 0, '0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 100, 4'hF, 1'b1, 1'b0);
    step(1'b1, 100, 4'hF, 1'b1, 1'b0);
    repeat (10) step(1'b0, 100, 4'hF, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
